// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the RV32I hazard controller: EX operand select
// codes, controller state encodings and the in-flight slot record.
package hazard_controller_pkg;

   localparam int RD_W  = 5;
   localparam int CNT_W = 3;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LDSTALL  = 2'b01,
      ST_REDIRECT = 2'b10
   } state_e;

   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rd;
      logic            we;
      logic            is_load;
   } slot_t;

   // Youngest producer wins: a hit in the EX slot shadows one in MEM.
   function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
      if (ex_hit)       return SEL_MEM;
      else if (mem_hit) return SEL_WB;
      else              return SEL_REG;
   endfunction

endpackage

// File: rtl/hazard_controller_slot_match.sv
// Compares one ID source register against one in-flight slot. x0 never
// matches because it is hardwired to zero and needs no forwarding.
module hazard_slot_match
   import hazard_controller_pkg::*;
(
   input  slot_t           slot_i,
   input  logic [RD_W-1:0] rs_i,
   input  logic            use_i,
   output logic            match_o
);

   assign match_o = slot_i.valid & slot_i.we & (slot_i.rd != '0)
                    & (slot_i.rd == rs_i) & use_i;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: tracks destinations in EX/MEM/WB, registers
// the EX operand forwarding selects, inserts a load-use bubble and squashes
// younger work on a misprediction.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal issue; forwarding and hazard detection active
// ST_LDSTALL  | one cycle after a load-use bubble; load now sits in MEM
// ST_REDIRECT | extra flush cycles after a redirect; ID and EX check ignored
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int REG_W        = RD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid_i,
   input  logic [REG_W-1:0] id_rs1_i,
   input  logic [REG_W-1:0] id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [REG_W-1:0] id_rd_i,
   input  logic             id_we_i,
   input  logic             id_is_load_i,
   input  logic             ex_is_valid_i,
   output logic [1:0]       A_sel_o,
   output logic [1:0]       B_sel_o,
   output logic             stall_o,
   output logic             bubble_ex_o,
   output logic             flush_if_id_o,
   output logic             redirect_o,
   output logic [1:0]       busy_state_o
);

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   slot_t            ex_q, mem_q, wb_q, ex_d;
   logic [1:0]       a_sel_q, b_sel_q, a_sel_d, b_sel_d;

   logic a_ex, b_ex, a_mem, b_mem;
   logic in_redir, mispred, load_use, stall, flush, bubble;

   hazard_slot_match u_a_ex  (.slot_i(ex_q),  .rs_i(id_rs1_i), .use_i(id_use_rs1_i), .match_o(a_ex));
   hazard_slot_match u_b_ex  (.slot_i(ex_q),  .rs_i(id_rs2_i), .use_i(id_use_rs2_i), .match_o(b_ex));
   hazard_slot_match u_a_mem (.slot_i(mem_q), .rs_i(id_rs1_i), .use_i(id_use_rs1_i), .match_o(a_mem));
   hazard_slot_match u_b_mem (.slot_i(mem_q), .rs_i(id_rs2_i), .use_i(id_use_rs2_i), .match_o(b_mem));

   // Hazard decode, next state and next slot/select contents.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_redir = (state_q == ST_REDIRECT);
      mispred  = !in_redir && ex_q.valid && !ex_is_valid_i;
      load_use = !in_redir && id_valid_i && ex_q.is_load && (a_ex || b_ex);
      stall    = load_use && !mispred;
      flush    = in_redir || mispred;
      bubble   = flush || stall;

      case (state_q)
         ST_RUN: begin
            if (mispred) begin
               if (FLUSH_CYCLES > 1) begin
                  state_d = ST_REDIRECT;
                  cnt_d   = FLUSH_LOAD;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (stall) begin
               state_d = ST_LDSTALL;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_LDSTALL: begin
            state_d = ST_RUN;
            if (mispred && (FLUSH_CYCLES > 1)) begin
               state_d = ST_REDIRECT;
               cnt_d   = FLUSH_LOAD;
            end
         end
         ST_REDIRECT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase

      ex_d    = '0;
      a_sel_d = SEL_REG;
      b_sel_d = SEL_REG;
      if (id_valid_i && !bubble) begin
         ex_d.valid   = 1'b1;
         ex_d.rd      = id_rd_i;
         ex_d.we      = id_we_i;
         ex_d.is_load = id_is_load_i;
         a_sel_d      = fwd_sel(a_ex, a_mem);
         b_sel_d      = fwd_sel(b_ex, b_mem);
      end
   end

   // State, flush counter, tracking slots and registered selects.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         a_sel_q <= SEL_REG;
         b_sel_q <= SEL_REG;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wb_q    <= mem_q;
         mem_q   <= ex_q;
         ex_q    <= ex_d;
         a_sel_q <= a_sel_d;
         b_sel_q <= b_sel_d;
      end
   end

   // Combinational controls are forced low while reset is held.
   assign stall_o       = reset & stall;
   assign bubble_ex_o   = reset & bubble;
   assign flush_if_id_o = reset & flush;
   assign redirect_o    = reset & mispred;
   assign A_sel_o       = a_sel_q;
   assign B_sel_o       = b_sel_q;
   assign busy_state_o  = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: the driver pushes per-cycle expectations computed from a
// behavioural model of the hazard rules; a monitor pops and compares.
module tb_hazard_controller;

   localparam int FC = 3;

   logic       clk = 0;
   logic       reset = 0;
   logic       id_valid_i = 0;
   logic [4:0] id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0;
   logic       id_use_rs1_i = 0, id_use_rs2_i = 0, id_we_i = 0, id_is_load_i = 0;
   logic       ex_is_valid_i = 1;
   logic [1:0] A_sel_o, B_sel_o, busy_state_o;
   logic       stall_o, bubble_ex_o, flush_if_id_o, redirect_o;

   hazard_controller #(.FLUSH_CYCLES(FC), .REG_W(5)) dut (
      .clk(clk), .reset(reset),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_is_load_i(id_is_load_i),
      .ex_is_valid_i(ex_is_valid_i),
      .A_sel_o(A_sel_o), .B_sel_o(B_sel_o), .stall_o(stall_o),
      .bubble_ex_o(bubble_ex_o), .flush_if_id_o(flush_if_id_o),
      .redirect_o(redirect_o), .busy_state_o(busy_state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       stall, bubble, flush, redir;
      bit [1:0] st, a, b;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Model: instructions that entered EX one (age 0) and two (age 1) cycles ago.
   bit   m_v[2], m_we[2], m_ld[2];
   int   m_rd[2];
   int   redir_left = 0;
   bit   ld_prev = 0;
   int   sel_a_cur = 0, sel_b_cur = 0;

   function automatic bit hits(int age, int rs, bit u);
      return m_v[age] && m_we[age] && m_rd[age] != 0 && m_rd[age] == rs && u;
   endfunction

   function automatic int youngest(int rs, bit u);
      if (hits(0, rs, u)) return 1;
      if (hits(1, rs, u)) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_v[i] = 0; m_we[i] = 0; m_ld[i] = 0; m_rd[i] = 0;
      end
      redir_left = 0; ld_prev = 0; sel_a_cur = 0; sel_b_cur = 0;
   endtask

   task automatic cyc(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we, bit ld, bit ok);
      exp_t e;
      bit   in_redir, mis, lu, enters;
      int   na, nb;
      @(negedge clk);
      reset = 1;
      id_valid_i = v; id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2);
      id_use_rs1_i = u1; id_use_rs2_i = u2; id_rd_i = 5'(rd);
      id_we_i = we; id_is_load_i = ld; ex_is_valid_i = ok;
      #2;
      in_redir = redir_left > 0;
      mis = !in_redir && m_v[0] && !ok;
      lu  = !in_redir && v && m_ld[0] && (hits(0, rs1, u1) || hits(0, rs2, u2));
      e.redir  = mis;
      e.stall  = lu && !mis;
      e.flush  = in_redir || mis;
      e.bubble = e.flush || e.stall;
      e.st     = in_redir ? 2'd2 : (ld_prev ? 2'd1 : 2'd0);
      e.a      = 2'(sel_a_cur);
      e.b      = 2'(sel_b_cur);
      q.push_back(e);
      enters = v && !e.bubble;
      na = enters ? youngest(rs1, u1) : 0;
      nb = enters ? youngest(rs2, u2) : 0;
      m_v[1] = m_v[0]; m_we[1] = m_we[0]; m_ld[1] = m_ld[0]; m_rd[1] = m_rd[0];
      m_v[0] = enters; m_we[0] = we; m_ld[0] = ld; m_rd[0] = rd;
      sel_a_cur = na; sel_b_cur = nb;
      if (in_redir)  redir_left = redir_left - 1;
      else if (mis)  redir_left = FC - 1;
      else           redir_left = 0;
      ld_prev = e.stall;
   endtask

   task automatic rst_cyc();
      exp_t e;
      @(negedge clk);
      reset = 0;
      id_valid_i = 1; id_is_load_i = 1; id_we_i = 1; ex_is_valid_i = 0;
      #2;
      e.stall = 0; e.bubble = 0; e.flush = 0; e.redir = 0;
      e.st = 0; e.a = 0; e.b = 0;
      q.push_back(e);
      model_reset();
   endtask

   task automatic chk(string nm, int got, int want);
      if (got != want) begin
         miscompares++;
         $display("FAIL vec %0d %s: got %0d want %0d", vectors, nm, got, want);
      end
   endtask

   // Monitor: compare every presented cycle against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk("stall",    int'(stall_o),       int'(e.stall));
            chk("bubble",   int'(bubble_ex_o),   int'(e.bubble));
            chk("flush",    int'(flush_if_id_o), int'(e.flush));
            chk("redirect", int'(redirect_o),    int'(e.redir));
            chk("state",    int'(busy_state_o),  int'(e.st));
            chk("A_sel",    int'(A_sel_o),       int'(e.a));
            chk("B_sel",    int'(B_sel_o),       int'(e.b));
         end
      end
   end

   task automatic nop();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      model_reset();
      rst_cyc(); rst_cyc();
      // back-to-back, gap of one, gap of two
      cyc(1, 0,0, 0,0, 5,1,0, 1); cyc(1, 5,1, 0,0, 9,1,0, 1); nop(); nop();
      cyc(1, 0,0, 0,0, 5,1,0, 1); cyc(1, 1,1, 2,1, 6,1,0, 1); cyc(1, 5,1, 0,0, 9,1,0, 1); nop();
      cyc(1, 0,0, 0,0, 5,1,0, 1); nop(); nop(); cyc(1, 5,1, 5,1, 9,1,0, 1); nop();
      // load-use, then the held instruction retries
      cyc(1, 0,0, 0,0, 7,1,1, 1); cyc(1, 7,1, 7,1, 8,1,0, 1); cyc(1, 7,1, 7,1, 8,1,0, 1); nop(); nop();
      // x0 producers never forward or stall
      cyc(1, 0,0, 0,0, 0,1,1, 1); cyc(1, 0,1, 0,1, 4,1,0, 1); cyc(1, 0,1, 0,1, 0,1,1, 1); nop(); nop();
      // mispredict beats simultaneous load-use, then extra flush cycles
      cyc(1, 0,0, 0,0, 7,1,1, 1); cyc(1, 7,1, 7,1, 8,1,0, 0);
      cyc(1, 7,1, 7,1, 8,1,1, 0); cyc(1, 7,1, 7,1, 8,1,1, 0); nop(); nop();
      // EX and MEM both write x3: youngest wins
      cyc(1, 0,0, 0,0, 3,1,0, 1); cyc(1, 0,0, 0,0, 3,1,0, 1); cyc(1, 3,1, 3,1, 10,1,0, 1); nop();
      // reset in the middle of REDIRECT
      cyc(1, 0,0, 0,0, 2,1,0, 1); cyc(1, 0,0, 0,0, 2,1,0, 0); cyc(1, 2,1, 0,0, 2,1,0, 1);
      rst_cyc();
      cyc(1, 0,0, 0,0, 6,1,0, 1); cyc(1, 6,1, 6,1, 11,1,0, 1); nop();
      // reset in the middle of LDSTALL
      cyc(1, 0,0, 0,0, 7,1,1, 1); cyc(1, 0,0, 7,1, 8,1,0, 1);
      rst_cyc();
      cyc(1, 0,0, 0,0, 6,1,0, 1); cyc(1, 0,0, 6,1, 11,1,0, 1); nop(); nop();
      // randomized traffic over a small register window
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(63) == 0) rst_cyc();
         else cyc($urandom_range(7) != 0,
                  $urandom_range(3), $urandom_range(1) == 1,
                  $urandom_range(3), $urandom_range(1) == 1,
                  $urandom_range(3), $urandom_range(3) != 0,
                  $urandom_range(2) == 0, $urandom_range(9) != 0);
      end
      nop(); nop();
      @(negedge clk); #5;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Sequencing controller for the RV32I 5-stage pipeline: tracks destination registers in flight through EX/MEM/WB and drives the EX-stage operand forwarding selects. Detects load-use hazards and inserts one bubble. On a branch/jump misprediction reported by EX, squashes younger instructions and redirects fetch to the corrected PC. Sits beside ID; its outputs feed the IF/ID and ID/EX pipeline registers, the PC mux and the EX operand muxes.

Parameters:
FLUSH_CYCLES, 1, cycles flush_if_id_o is held after a redirect (covers fetch latency); range 1..7
REG_W, 5, register index width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous active-low reset
id_valid_i  in  1  ID holds a real instruction
id_rs1_i  in  REG_W  ID source 1
id_rs2_i  in  REG_W  ID source 2
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
id_rd_i  in  REG_W  ID destination
id_we_i  in  1  ID instruction writes rd
id_is_load_i  in  1  ID instruction is a load
ex_is_valid_i  in  1  EX prediction check (1 = prediction correct)
A_sel_o  out  2  EX operand A select, registered
B_sel_o  out  2  EX operand B select, registered
stall_o  out  1  hold PC and IF/ID (combinational)
bubble_ex_o  out  1  load NOP into ID/EX (combinational)
flush_if_id_o  out  1  squash IF/ID (combinational)
redirect_o  out  1  PC <= Correct_PC this edge (combinational)
busy_state_o  out  2  current FSM state, debug

Behaviour:
- Select encoding (matches EX muxes): 00 register-file operand, 01 Data_MEM, 10 Data_WB, 11 reserved (never driven).
- Tracking slots EX, MEM, WB, each {valid, rd, we, is_load}. Each edge: WB<=MEM, MEM<=EX; EX<=ID info if id_valid_i and no stall/flush/REDIRECT state, else bubble (valid=0).
- A slot "matches" rs when valid & we & rd!=0 & rd==rs & corresponding id_use bit set.
- Forwarding (computed for ID, registered into A_sel_o/B_sel_o at edge as instruction enters EX): EX-slot match -> 01; else MEM-slot match -> 10; else 00. Youngest wins. Register file is write-first, so WB-slot matches need no forwarding.
- Load-use: EX-slot match with is_load=1 -> stall_o=1, bubble_ex_o=1 for exactly one cycle; next cycle the load is in MEM and the select resolves to 10. Sels registered during a stall are 00 (bubble).
- Mispredict: EX slot valid & ex_is_valid_i=0 -> redirect_o=1 and flush_if_id_o=1 and bubble_ex_o=1 in that cycle; stall_o forced 0 (mispredict beats load-use). The EX instruction itself commits.
- FSM: RUN (00), LDSTALL (01), REDIRECT (10).
  RUN -> LDSTALL on load-use; RUN -> REDIRECT on mispredict with FLUSH_CYCLES>1 (counter loaded FLUSH_CYCLES-1).
  LDSTALL -> RUN unconditionally; mispredict in LDSTALL handled as in RUN (-> REDIRECT or RUN).
  REDIRECT: flush_if_id_o=1, bubble_ex_o=1, ID inputs ignored, ex_is_valid_i ignored (EX holds bubbles); counter decrements, -> RUN at 0.
- Reset (any time, async): all slots invalid, sels 00, state RUN, counter 0, all combinational outputs 0 while reset low.
- id_valid_i=0 -> no stall, bubble tracked.

Decomposition:
- Shared package: select codes (SEL_REG, SEL_MEM, SEL_WB), FSM state encodings, slot record typedef.
- One sub-module natural: hazard_slot_match (combinational rs-vs-slot compare, instantiated per source per slot).

Test Plan:
- add x5 then add using x5 as rs1 back-to-back -> A_sel_o=01 on second's EX cycle; gap of one instr -> 10; gap of two -> 00.
- lw x7 then add x8,x7,x7 -> stall_o=1, bubble_ex_o=1 one cycle, state 01, then A_sel_o=B_sel_o=10, no second stall.
- instruction writing x0 followed by reader of x0 -> sels 00, no stall, even if load.
- ex_is_valid_i=0 with EX valid and simultaneous load-use -> redirect_o=1, flush_if_id_o=1, stall_o=0; FLUSH_CYCLES=3 -> flush held 3 cycles total, state 10 for 2, then RUN.
- EX and MEM both write x3, ID reads x3 -> 01 (youngest wins).
- reset low mid-REDIRECT and mid-LDSTALL -> outputs 0/00 immediately, state RUN, next dependent pair forwards correctly after release.
